window_gen_pad: RTL and testbench

WINDOW_GEN_PAD -- requirements
Module: window_gen_pad

---
 rtl/window_pkg.sv | 21 ++
 rtl/line_buffer.sv | 40 ++++
 rtl/window_gen_pad.sv | 247 ++++++++++++++++++++++++
 tb/tb_window_gen_pad.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// window_pkg: shared definitions for the 3x3 window generator.
//   state_e         - control FSM states (IDLE, RUN, FLUSH, DRAIN)
//   DEFAULT_MAX_DIM - default maximum square feature-map dimension
//   dim_width()     - width of the row/column counters and the dimension config
package window_pkg;

  localparam int DEFAULT_MAX_DIM = 224;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // Counters must reach MAX_DIM itself (the padded virtual column/row), hence +2.
  function automatic int dim_width(input int max_dim);
    return $clog2(max_dim + 2);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: two image rows of pixel storage sharing one address.
//   clock             - clock
//   wr_en, wr_addr    - write both rows at wr_addr
//   wr_data0/1        - new contents of row 0 (most recent row) and row 1 (older row)
//   rd_addr           - read address, registered read (one cycle latency)
//   rd_data0/1        - registered read data of row 0 / row 1
// No reset: contents are never assumed valid before they are written.
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 224,
  parameter int ADDR_W     = 8
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data0,
  input  logic [DATA_WIDTH-1:0] wr_data1,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data0,
  output logic [DATA_WIDTH-1:0] rd_data1
);

  logic [DATA_WIDTH-1:0] row0_mem [DEPTH];
  logic [DATA_WIDTH-1:0] row1_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd0_q;
  logic [DATA_WIDTH-1:0] rd1_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      row0_mem[wr_addr] <= wr_data0;
      row1_mem[wr_addr] <= wr_data1;
    end
    rd0_q <= row0_mem[rd_addr];
    rd1_q <= row1_mem[rd_addr];
  end

  assign rd_data0 = rd0_q;
  assign rd_data1 = rd1_q;

endmodule

// File: rtl/window_gen_pad.sv
// window_gen_pad: streams a raster-order square image and emits 3x3 windows
// with optional zero padding ("same") and stride 1 or 2.
//   clock, reset_n        - clock, asynchronous active-low reset
//   start, cfg_dim,
//   cfg_stride, cfg_pad   - frame start and configuration, sampled in IDLE
//   in_data/valid/ready   - pixel input stream
//   out_window/valid/
//   ready/last            - window output stream, index 3*row+col, row 0 on top
//   busy                  - block is processing a frame
//   cfg_err               - one-cycle pulse for a start with an illegal cfg_dim
module window_gen_pad
  import window_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_DIM    = DEFAULT_MAX_DIM,
  localparam int DIM_W      = dim_width(MAX_DIM)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [DIM_W-1:0]           cfg_dim,
  input  logic                       cfg_stride,
  input  logic                       cfg_pad,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [8:0][DATA_WIDTH-1:0] out_window,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       cfg_err
);

  state_e state_q, state_d;

  logic [DIM_W-1:0] dim_q, dim_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] last_rc_q, last_rc_d;
  logic             stride_q, stride_d;
  logic             pad_q, pad_d;
  logic             done_q, done_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             cfg_err_q, cfg_err_d;
  logic [8:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [8:0][DATA_WIDTH-1:0] out_win_q, out_win_d;

  logic                  cfg_legal, start_ok;
  logic [DIM_W-1:0]      cfg_last_rc, col_max, lb_rd_addr;
  logic                  in_run, in_flush, virt_col, stage_free, fire;
  logic                  row_end, last_acc, frame_done;
  logic                  emit, emit_last, lb_wr_en;
  logic [DATA_WIDTH-1:0] beat_data, rd0, rd1;
  logic [2:0][DATA_WIDTH-1:0] new_col;
  logic [8:0][DATA_WIDTH-1:0] win_shift;

  assign cfg_legal = (cfg_dim >= DIM_W'(3)) && (cfg_dim <= DIM_W'(MAX_DIM));
  assign start_ok  = (state_q == S_IDLE) && start && cfg_legal;

  // Bottom-right coordinate (same for row and column) of the frame's final window.
  always_comb begin
    if (cfg_pad) begin
      cfg_last_rc = (cfg_stride && !cfg_dim[0]) ? cfg_dim - DIM_W'(1) : cfg_dim;
    end else begin
      cfg_last_rc = (cfg_stride && !cfg_dim[0]) ? cfg_dim - DIM_W'(2) : cfg_dim - DIM_W'(1);
    end
  end

  assign in_run     = (state_q == S_RUN);
  assign in_flush   = (state_q == S_FLUSH);
  assign col_max    = pad_q ? dim_q : dim_q - DIM_W'(1);
  // Padded rows carry one extra zero column at index dim.
  assign virt_col   = pad_q && (col_q == dim_q);
  assign stage_free = !out_valid_q || out_ready;
  assign fire       = stage_free && (in_flush || (in_run && (virt_col || in_valid)));
  assign beat_data  = (in_run && !virt_col) ? in_data : '0;
  assign row_end    = fire && (col_q == col_max);
  assign last_acc   = out_valid_q && out_last_q && out_ready;
  // The final window may precede the final beat (stride 2), so remember its acceptance.
  assign frame_done = done_q || last_acc;

  always_comb begin
    if (pad_q) begin
      emit = (row_q >= DIM_W'(1)) && (col_q >= DIM_W'(1)) &&
             (!stride_q || (row_q[0] && col_q[0]));
    end else begin
      emit = (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2)) &&
             (!stride_q || (!row_q[0] && !col_q[0]));
    end
  end
  assign emit_last = emit && (row_q == last_rc_q) && (col_q == last_rc_q);

  // Virtual padding column is all zeros; the flush row only zeroes the bottom pixel.
  assign new_col[0] = virt_col ? '0 : rd1;
  assign new_col[1] = virt_col ? '0 : rd0;
  assign new_col[2] = beat_data;

  always_comb begin
    win_shift = '0;
    for (int r = 0; r < 3; r++) begin
      win_shift[3*r]   = win_q[3*r+1];
      win_shift[3*r+1] = win_q[3*r+2];
      win_shift[3*r+2] = new_col[r];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (row_end && (row_q == dim_q - DIM_W'(1))) begin
                 if (pad_q)           state_d = S_FLUSH;
                 else if (frame_done) state_d = S_IDLE;
                 else                 state_d = S_DRAIN;
               end
      S_FLUSH: if (row_end) state_d = frame_done ? S_IDLE : S_DRAIN;
      S_DRAIN: if (last_acc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Outputs decoded from state
  always_comb begin
    busy     = (state_q != S_IDLE);
    in_ready = in_run && !virt_col && stage_free;
  end

  // Datapath next values
  always_comb begin
    dim_d       = dim_q;
    stride_d    = stride_q;
    pad_d       = pad_q;
    last_rc_d   = last_rc_q;
    row_d       = row_q;
    col_d       = col_q;
    win_d       = win_q;
    done_d      = done_q;
    out_win_d   = out_win_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cfg_err_d   = (state_q == S_IDLE) && start && !cfg_legal;

    if (start_ok) begin
      dim_d     = cfg_dim;
      stride_d  = cfg_stride;
      pad_d     = cfg_pad;
      last_rc_d = cfg_last_rc;
      row_d     = '0;
      col_d     = '0;
      win_d     = '0;
      done_d    = 1'b0;
    end else if (fire) begin
      win_d = win_shift;
      if (col_q == col_max) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end

    if (last_acc) done_d = 1'b1;

    if (fire && emit) begin
      out_valid_d = 1'b1;
      out_last_d  = emit_last;
      // Top row lies above the image on row 1, left column left of it on column 1.
      for (int i = 0; i < 9; i++) begin
        if (pad_q && (((row_q == DIM_W'(1)) && (i < 3)) ||
                      ((col_q == DIM_W'(1)) && ((i % 3) == 0)))) begin
          out_win_d[i] = '0;
        end else begin
          out_win_d[i] = win_shift[i];
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dim_q       <= '0;
      stride_q    <= 1'b0;
      pad_q       <= 1'b0;
      last_rc_q   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      win_q       <= '0;
      done_q      <= 1'b0;
      out_win_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      dim_q       <= dim_d;
      stride_q    <= stride_d;
      pad_q       <= pad_d;
      last_rc_q   <= last_rc_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_q       <= win_d;
      done_q      <= done_d;
      out_win_q   <= out_win_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Reading the next column one cycle ahead makes the registered read line up
  // with the beat; the column being written never equals the one being read.
  // Only real columns are stored; the padding column index is clamped.
  assign lb_wr_en   = fire && in_run && !virt_col;
  assign lb_rd_addr = (col_d < DIM_W'(MAX_DIM)) ? col_d : '0;

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_DIM),
    .ADDR_W     (DIM_W)
  ) u_line_buffer (
    .clock    (clock),
    .wr_en    (lb_wr_en),
    .wr_addr  (col_q),
    .wr_data0 (beat_data),
    .wr_data1 (rd0),
    .rd_addr  (lb_rd_addr),
    .rd_data0 (rd0),
    .rd_data1 (rd1)
  );

  assign out_window = out_win_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_window_gen_pad.sv
module tb_window_gen_pad;
  import window_pkg::*;

  localparam int DW    = 8;
  localparam int MAXD  = DEFAULT_MAX_DIM;
  localparam int DIM_W = dim_width(MAXD);

  typedef logic [8:0][DW-1:0] win_t;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [DIM_W-1:0] cfg_dim;
  logic             cfg_stride;
  logic             cfg_pad;
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  win_t             out_window;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             cfg_err;

  window_gen_pad #(.DATA_WIDTH(DW), .MAX_DIM(MAXD)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .cfg_dim    (cfg_dim),
    .cfg_stride (cfg_stride),
    .cfg_pad    (cfg_pad),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_window (out_window),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int got_windows = 0;
  int ready_mode  = 0;  // 0: always ready, 1: toggle each cycle, 2: random

  logic [DW-1:0] pix [MAXD*MAXD];
  win_t exp_win_q[$];
  bit   exp_last_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, need %0h", name, act, req);
    end
  endtask

  task automatic report_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out", name);
  endtask

  // Reference: enumerate output positions directly from the geometry.
  task automatic model_frame(input int dim, input int stride, input int pad, output int n_win);
    int n, y, x;
    win_t w;
    n = pad ? (dim + stride - 1) / stride : (dim - 3) / stride + 1;
    for (int oy = 0; oy < n; oy++) begin
      for (int ox = 0; ox < n; ox++) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            y = oy * stride + r - pad;
            x = ox * stride + c - pad;
            if (y < 0 || x < 0 || y >= dim || x >= dim) w[3*r+c] = '0;
            else                                        w[3*r+c] = pix[y*dim + x];
          end
        end
        exp_win_q.push_back(w);
        exp_last_q.push_back((oy == n - 1) && (ox == n - 1));
      end
    end
    n_win = n * n;
  endtask

  // Output-side ready generator
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Scoreboard monitor
  win_t prev_win;
  bit   prev_stall = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_window", out_window, prev_win);
      end
      if (out_valid && !out_ready) check("in_ready_while_stalled", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        if (exp_win_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_window: got %0h, need none", out_window);
        end else begin
          check("window", out_window, exp_win_q.pop_front());
          check("out_last", out_last, exp_last_q.pop_front());
          got_windows++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_win   = out_window;
    end
  end

  task automatic start_frame(input int dim, input int s_sel, input int pad);
    cfg_dim    = DIM_W'(dim);
    cfg_stride = s_sel[0];
    cfg_pad    = pad[0];
    start      = 1'b1;
    @(posedge clock);
    #1;
    start      = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic feed(input int n, input int gap_pct);
    bit acc;
    int cyc;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clock);
        #1;
      end
      in_valid = 1'b1;
      in_data  = pix[i];
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 200) begin
        @(negedge clock);
        acc = in_ready;
        @(posedge clock);
        #1;
        cyc++;
      end
      if (!acc) begin
        report_timeout("input_accept");
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((busy || exp_win_q.size() != 0) && cyc < 5000) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    if (busy || exp_win_q.size() != 0) report_timeout("frame_completion");
  endtask

  task automatic run_frame(input int dim, input int s_sel, input int pad, input bit rnd,
                           input int gap_pct, input int rmode);
    int n_win;
    ready_mode = rmode;
    for (int i = 0; i < dim * dim; i++) pix[i] = rnd ? DW'($urandom_range(1, 255)) : DW'(i + 1);
    got_windows = 0;
    model_frame(dim, s_sel + 1, pad, n_win);
    start_frame(dim, s_sel, pad);
    feed(dim * dim, gap_pct);
    wait_idle();
    check("window_count", got_windows, n_win);
    ready_mode = 0;
  endtask

  task automatic bad_start(input int dim);
    int pulses = 0;
    cfg_dim = DIM_W'(dim);
    start   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (cfg_err) pulses++;
      check("busy_after_bad_start", busy, 1'b0);
    end
    check("cfg_err_pulses", pulses, 1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n_dummy;
    reset_n    = 1'b0;
    start      = 1'b0;
    cfg_dim    = '0;
    cfg_stride = 1'b0;
    cfg_pad    = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    #2;
    check("reset_busy", busy, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_last", out_last, 1'b0);
    check("reset_cfg_err", cfg_err, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run_frame(4, 0, 0, 1'b0, 0, 0);   // valid, stride 1, pixels 1..16
    run_frame(4, 1, 1, 1'b0, 0, 0);   // same, stride 2, pixels 1..16
    run_frame(5, 0, 0, 1'b1, 0, 1);   // toggling out_ready

    bad_start(2);
    bad_start(MAXD + 1);

    // Abandon a dim=7 frame mid-stream, then run a fresh 3x3 frame.
    ready_mode = 0;
    for (int i = 0; i < 49; i++) pix[i] = DW'($urandom_range(1, 255));
    got_windows = 0;
    model_frame(7, 1, 0, n_dummy);
    start_frame(7, 0, 0);
    feed(30, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_in_ready", in_ready, 1'b0);
    check("midreset_out_last", out_last, 1'b0);
    exp_win_q.delete();
    exp_last_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_frame(3, 0, 0, 1'b1, 0, 0);

    for (int k = 0; k < 6; k++) begin
      run_frame($urandom_range(3, 12), $urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 30, 2);
    end

    run_frame(MAXD, 1, 1, 1'b1, 12, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
